// File: rtl/rom_ram_pkg.sv
// Shared constants, state encoding and count clamp for the ROM-to-RAM copier.
package rom_ram_pkg;

  localparam int unsigned ROM_AW    = 4;
  localparam int unsigned RAM_AW    = 2;
  localparam int unsigned DW        = 16;
  localparam int unsigned CW        = 3;
  localparam int unsigned MAX_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    WRITE   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Requests above the RAM depth are trimmed to a full-RAM copy.
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    return (c > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : c;
  endfunction

endpackage

// File: rtl/rom_ram_copier.sv
// Clocked copy controller: moves up to four words from rom_16 into ram_4
// with a start/busy/done handshake and a running 16-bit checksum.
module rom_ram_copier
  import rom_ram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] src_base,
  input  logic [RAM_AW-1:0] dst_base,
  input  logic [CW-1:0]     count,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [DW-1:0]     rom_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_in,
  output logic              ram_rw,
  output logic              ram_cs,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     checksum
);

  state_t            state;
  logic [ROM_AW-1:0] src_reg;
  logic [RAM_AW-1:0] dst_reg;
  logic [CW-1:0]     cnt_reg;
  logic [CW-1:0]     idx;
  logic [DW-1:0]     data_reg;
  logic [CW-1:0]     count_clamped;

  assign count_clamped = clamp_count(count);

  // Copy sequencer: one FETCH/LATCH/WRITE/RELEASE round per word.
  // RAM address and data are loaded in LATCH so they are already stable for
  // a full cycle when WRITE raises ram_rw.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      src_reg  <= '0;
      dst_reg  <= '0;
      cnt_reg  <= '0;
      idx      <= '0;
      data_reg <= '0;
      rom_addr <= '0;
      rom_cs   <= 1'b0;
      ram_addr <= '0;
      ram_in   <= '0;
      ram_rw   <= 1'b0;
      ram_cs   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_reg  <= src_base;
            dst_reg  <= dst_base;
            cnt_reg  <= count_clamped;
            idx      <= '0;
            checksum <= '0;
            if (count_clamped == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          rom_addr <= src_reg + ROM_AW'(idx);
          rom_cs   <= 1'b1;
          ram_rw   <= 1'b0;
          state    <= LATCH;
        end
        LATCH: begin
          data_reg <= rom_data;
          ram_addr <= dst_reg + RAM_AW'(idx);
          ram_in   <= rom_data;
          state    <= WRITE;
        end
        WRITE: begin
          ram_cs   <= 1'b1;
          ram_rw   <= 1'b1;
          checksum <= checksum + data_reg;
          state    <= RELEASE;
        end
        RELEASE: begin
          ram_rw <= 1'b0;
          ram_cs <= 1'b0;
          rom_cs <= 1'b0;
          idx    <= idx + CW'(1);
          if (idx + CW'(1) == cnt_reg) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
